// File: rtl/baser_pkg.sv
// Shared constants and types for the BASE-R 66b transmit encoder:
// sync headers, block types, MII characters and the sequence-state enum.
package baser_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_OSEQ  = 8'h4B;
    localparam logic [7:0] BT_T0    = 8'h87;
    localparam logic [7:0] BT_T1    = 8'h99;
    localparam logic [7:0] BT_T2    = 8'hAA;
    localparam logic [7:0] BT_T3    = 8'hB4;
    localparam logic [7:0] BT_T4    = 8'hCC;
    localparam logic [7:0] BT_T5    = 8'hD2;
    localparam logic [7:0] BT_T6    = 8'hE1;
    localparam logic [7:0] BT_T7    = 8'hFF;

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_ERR   = 8'hFE;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_SEQ   = 8'h9C;

    localparam logic [6:0] CC_IDLE = 7'h00;
    localparam logic [6:0] CC_ERR  = 7'h1E;

    // Payload of the block substituted for anything illegal: type 0x1E, eight error chars.
    localparam logic [63:0] ERR_PAYLOAD = {BT_IDLE, {8{CC_ERR}}};

    typedef enum logic [2:0] {
        TX_INIT,
        TX_C,
        TX_D,
        TX_T,
        TX_E
    } tx_state_t;

    typedef enum logic [2:0] {
        CLS_C,
        CLS_S,
        CLS_D,
        CLS_T,
        CLS_E
    } blk_class_t;

    function automatic logic [7:0] term_type(input logic [2:0] n);
        logic [7:0] t;
        case (n)
            3'd0:    t = BT_T0;
            3'd1:    t = BT_T1;
            3'd2:    t = BT_T2;
            3'd3:    t = BT_T3;
            3'd4:    t = BT_T4;
            3'd5:    t = BT_T5;
            3'd6:    t = BT_T6;
            default: t = BT_T7;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] term_mask(input logic [2:0] n);
        return 8'hFF << n;
    endfunction

endpackage

// File: rtl/baser_66b_block_enc.sv
// Combinational MII-word to 66b block encoder; also reports the block class
// (C/S/D/T/E) that drives the transmit sequence state machine.
module baser_66b_block_enc
    import baser_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] i_txd,
    input  logic [CTRL_WIDTH-1:0] i_txc,
    output logic [HDR_WIDTH-1:0]  o_hdr,
    output logic [DATA_WIDTH-1:0] o_payload,
    output blk_class_t            o_class
);

    logic [7:0] lane [8];
    logic [7:0] ctrl_ok;
    logic [7:0] hi_idle;
    logic       found;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane[k]    = i_txd[8*k +: 8];
            ctrl_ok[k] = (lane[k] == MII_IDLE) || (lane[k] == MII_ERR);
        end
        // hi_idle[k]: every lane above k carries an idle character
        hi_idle    = '0;
        hi_idle[7] = 1'b1;
        for (int k = 6; k >= 0; k--) begin
            hi_idle[k] = hi_idle[k+1] && (lane[k+1] == MII_IDLE);
        end

        o_hdr     = SH_CTRL;
        o_payload = ERR_PAYLOAD;
        o_class   = CLS_E;
        found     = 1'b0;

        if (i_txc == 8'h00) begin
            o_hdr   = SH_DATA;
            o_class = CLS_D;
            for (int p = 0; p < 8; p++) begin
                o_payload[63-8*p -: 8] = lane[p];
            end
        end else if ((i_txc == 8'hFF) && (&ctrl_ok)) begin
            o_class          = CLS_C;
            o_payload        = '0;
            o_payload[63:56] = BT_IDLE;
            for (int k = 0; k < 8; k++) begin
                o_payload[55-7*k -: 7] = (lane[k] == MII_ERR) ? CC_ERR : CC_IDLE;
            end
        end else if ((i_txc == 8'h01) && (lane[0] == MII_START)) begin
            o_class          = CLS_S;
            o_payload[63:56] = BT_START;
            for (int p = 1; p < 8; p++) begin
                o_payload[63-8*p -: 8] = lane[p];
            end
        end else if ((i_txc == 8'hF1) && (lane[0] == MII_SEQ) && hi_idle[3]) begin
            // Ordered set: O-code 0 and idle chars all encode as zero bits
            o_class   = CLS_C;
            o_payload = {BT_OSEQ, lane[1], lane[2], lane[3], 32'h0};
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (!found && (i_txc == term_mask(3'(n))) && (lane[n] == MII_TERM) && hi_idle[n]) begin
                    found            = 1'b1;
                    o_class          = CLS_T;
                    o_payload        = '0;
                    o_payload[63:56] = term_type(3'(n));
                    for (int k = 0; k < 7; k++) begin
                        if (k < n) begin
                            o_payload[55-8*k -: 8] = lane[k];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/baser_66b_encoder.sv
// BASE-R 66b transmit encoder: sequence FSM, error substitution, counters and
// 4-block output grouping. Define BASER_SCRAMBLER_EN to scramble payloads.
module baser_66b_encoder
    import baser_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_SLOTS   = 4
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_txd,
    input  logic [CTRL_WIDTH-1:0]  i_txc,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_0,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_1,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_2,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_3,
    output logic                   o_valid,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_err_count
);

    localparam int               PTR_W    = $clog2(NUM_SLOTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SLOTS - 1);

    logic [HDR_WIDTH-1:0]   enc_hdr;
    logic [DATA_WIDTH-1:0]  enc_payload;
    blk_class_t             enc_class;

    tx_state_t              state_q, state_d;
    logic                   err_blk;
    logic [HDR_WIDTH-1:0]   blk_hdr;
    logic [DATA_WIDTH-1:0]  blk_pl;
    logic [DATA_WIDTH-1:0]  tx_pl;
    logic [FRAME_WIDTH-1:0] tx_blk;

    logic [PTR_W-1:0]       ptr_q;
    logic [FRAME_WIDTH-1:0] slot_q [NUM_SLOTS];
    logic [FRAME_WIDTH-1:0] grp_q  [NUM_SLOTS];
    logic                   valid_q;
    logic [31:0]            blk_cnt_q, data_cnt_q, ctrl_cnt_q, err_cnt_q;

    baser_66b_block_enc #(
        .DATA_WIDTH (DATA_WIDTH),
        .HDR_WIDTH  (HDR_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_enc (
        .i_txd     (i_txd),
        .i_txc     (i_txc),
        .o_hdr     (enc_hdr),
        .o_payload (enc_payload),
        .o_class   (enc_class)
    );

    always_comb begin
        state_d = state_q;
        if (i_valid) begin
            unique case (state_q)
                TX_D: begin
                    case (enc_class)
                        CLS_D:   state_d = TX_D;
                        CLS_T:   state_d = TX_T;
                        default: state_d = TX_E;
                    endcase
                end
                TX_E: begin
                    case (enc_class)
                        CLS_C:   state_d = TX_C;
                        CLS_S:   state_d = TX_D;
                        CLS_D:   state_d = TX_D;
                        CLS_T:   state_d = TX_T;
                        default: state_d = TX_E;
                    endcase
                end
                default: begin
                    case (enc_class)
                        CLS_C:   state_d = TX_C;
                        CLS_S:   state_d = TX_D;
                        default: state_d = TX_E;
                    endcase
                end
            endcase
        end
        // Any accepted word that lands in TX_E is replaced, legal or not
        err_blk = i_valid && (state_d == TX_E);
        blk_hdr = err_blk ? SH_CTRL : enc_hdr;
        blk_pl  = err_blk ? ERR_PAYLOAD : enc_payload;
    end

`ifdef BASER_SCRAMBLER_EN
    logic [57:0] scr_q, scr_d;

    always_comb begin
        scr_d = scr_q;
        tx_pl = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            tx_pl[i] = blk_pl[i] ^ scr_d[38] ^ scr_d[57];
            scr_d    = {scr_d[56:0], tx_pl[i]};
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            scr_q <= '1;
        end else if (i_valid) begin
            scr_q <= scr_d;
        end
    end
`else
    assign tx_pl = blk_pl;
`endif

    assign tx_blk = {blk_hdr, tx_pl};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= TX_INIT;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            blk_cnt_q  <= '0;
            data_cnt_q <= '0;
            ctrl_cnt_q <= '0;
            err_cnt_q  <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= '0;
                grp_q[s]  <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (i_valid) begin
                state_q       <= state_d;
                ptr_q         <= ptr_q + 1'b1;
                slot_q[ptr_q] <= tx_blk;
                // Last slot: publish the three buffered blocks plus this one
                if (ptr_q == PTR_LAST) begin
                    for (int s = 0; s < NUM_SLOTS - 1; s++) begin
                        grp_q[s] <= slot_q[s];
                    end
                    grp_q[NUM_SLOTS-1] <= tx_blk;
                    valid_q            <= 1'b1;
                end
                blk_cnt_q <= blk_cnt_q + 32'd1;
                if (blk_hdr == SH_DATA) begin
                    data_cnt_q <= data_cnt_q + 32'd1;
                end else begin
                    ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
                end
                if (err_blk) begin
                    err_cnt_q <= err_cnt_q + 32'd1;
                end
            end
        end
    end

    assign o_tx_coded_0  = grp_q[0];
    assign o_tx_coded_1  = grp_q[1];
    assign o_tx_coded_2  = grp_q[2];
    assign o_tx_coded_3  = grp_q[3];
    assign o_valid       = valid_q;
    assign o_block_count = blk_cnt_q;
    assign o_data_count  = data_cnt_q;
    assign o_ctrl_count  = ctrl_cnt_q;
    assign o_err_count   = err_cnt_q;

endmodule

// File: doc/baser_66b_encoder.md
Name: baser_66b_encoder

Overview:
- Transmit-side counterpart of the BASE-R 66b receive checker.
- Accepts one 64-bit MII word per valid cycle and encodes it into a 66b block (Clause 82 style).
- Runs a transmit sequence state machine and forces error blocks on illegal sequences.
- Packs four consecutive blocks into a 4-slot buffer, presented as one group on o_tx_coded_0..3.

Parameters:
- DATA_WIDTH, 64, MII data width and 66b payload width.
- HDR_WIDTH, 2, sync header width.
- FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH, coded block width.
- CTRL_WIDTH, DATA_WIDTH/8, MII control width.
- NUM_SLOTS, 4, blocks per output group (fixed at 4).

Ports:
- clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  MII word valid; i_txd/i_txc are sampled only when high
- i_txd  input  DATA_WIDTH  MII data; lane k = [8k+7:8k]
- i_txc  input  CTRL_WIDTH  MII control; bit k set = lane k is a control char
- o_tx_coded_0  output  FRAME_WIDTH  1st block of group (oldest)
- o_tx_coded_1  output  FRAME_WIDTH  2nd block
- o_tx_coded_2  output  FRAME_WIDTH  3rd block
- o_tx_coded_3  output  FRAME_WIDTH  4th block (newest)
- o_valid  output  1  one-cycle pulse; group outputs updated
- o_block_count  output  32  total blocks encoded
- o_data_count  output  32  data blocks (sh=01)
- o_ctrl_count  output  32  control blocks (sh=10)
- o_err_count  output  32  blocks replaced by an error block

Behaviour:
- Reset: all outputs 0, slot pointer 0, state TX_INIT, buffer cleared.
- Block format: [65:64]=sync header. Payload byte p occupies [63-8p:56-8p].
- Data block: i_txc==0 -> sh=2'b01, payload byte p = MII lane p.
- Control block: sh=2'b10, byte0 = block type.
- Control char map (MII to 7-bit): idle 0x07->0x00, error 0xFE->0x1E.
- MII specials: start 0xFB, terminate 0xFD, sequence 0x9C.
- Type 0x1E: all 8 lanes control idle/error; eight 7-bit chars in [55:0], lane0 at [55:49].
- Type 0x78: lane0=0xFB, other lanes data; lanes1..7 go to bytes 1..7.
- Type 0x4B: lane0=0x9C, lanes1..3 data, lanes4..7 idle; O-code=0x0 in [31:28], rest 0.
- Type Tn, n=0..7 (0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF): lane n=0xFD, lanes<n data, lanes>n idle.
  - Data bytes packed from byte1; idle chars as 7-bit 0x00; unused bits 0.
- Any other i_txc/i_txd combination is invalid -> type 0x1E with all chars 0x1E; o_err_count increments.
- Sequence state machine (states TX_INIT, TX_C, TX_D, TX_T, TX_E), advances only on i_valid:
  - Input class: C=0x1E/0x4B, S=0x78, D=data, T=Tn, E=invalid.
  - TX_INIT: C->TX_C, S->TX_D, other->TX_E.
  - TX_C: C->TX_C, S->TX_D, other->TX_E.
  - TX_D: D->TX_D, T->TX_T, other->TX_E.
  - TX_T: C->TX_C, S->TX_D, other->TX_E.
  - TX_E: C->TX_C, S->TX_D, D->TX_D, T->TX_T, E->TX_E.
  - Entering TX_E emits the error block (o_err_count+1), even if the block itself was legal.
- Counters: each accepted word increments o_block_count. Exactly one of data/ctrl increments per the emitted sh; error blocks count as ctrl.
  - All counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Buffering:
  - Encoded block is written into slot[ptr] on the clock edge of the accepting cycle; ptr then increments mod 4.
  - When slot 3 is written, slots 0..3 (including the current block) load into o_tx_coded_0..3 together.
  - o_valid is high the cycle after the 4th accept. Latency from 4th accept edge = 1 cycle.
- i_valid low: ptr, state, buffer and outputs hold; o_valid=0.
- Outputs hold their last group between pulses.
- Reset mid-group discards any partial group.

Optional Feature:
- Macro BASER_SCRAMBLER_EN.
- Defined: payload [63:0] passes through a self-synchronous scrambler, x^58+x^39+1, bit 63 first.
  - Scrambler state is 58 bits, reset to all-ones, and advances only on accepted words.
  - Sync header is never scrambled.
- Undefined: payload is unscrambled and no scrambler state exists.

Decomposition:
- Package baser_pkg holds:
  - sync header constants SH_DATA=2'b01, SH_CTRL=2'b10;
  - block type constants;
  - MII char constants (0x07, 0xFE, 0xFB, 0xFD, 0x9C);
  - the tx_state_t enum.
- Sub-module baser_66b_block_enc: combinational MII-to-66b encode plus block class output (C/S/D/T/E). The top holds the FSM, buffer, counters and scrambler.

Test Plan:
- Reset, then 4 words of all idle (txd=0x0707070707070707, txc=0xFF) -> o_valid pulses once; each block = 66'h2_1E00000000000000; ctrl_count=4.
- Sequence S(lane0=0xFB, lanes1..7=0x11..0x77), D, D, T0 -> blocks 10_78.., 01_.., 01_.., 10_87..; data_count=2; err_count=0.
- D word directly after reset -> block 10_1E with chars 0x1E; err_count=1; state TX_E. Next idle -> TX_C.
- Insert i_valid=0 gaps of 3 cycles between accepts -> o_valid only after the 4th accept; outputs hold during gaps.
- Assert i_rst after 2 accepts -> all counters 0, no o_valid. The next 4 accepts form a fresh group.
- With BASER_SCRAMBLER_EN, 4 idle blocks -> payloads match the reference scrambler model from all-ones seed; headers stay 10.
